// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared helpers for the burst width converters
`ifndef BURST_PKG_SV
`define BURST_PKG_SV

`define BURST_RATIO_CHECK(ratio) \
  if ((ratio) < 2) begin : g_bad_ratio \
    $error("burst: RATIO must be >= 2"); \
  end

package burst_pkg;

  function automatic int beat_idx_w(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

`endif

// File: rtl/intf_burst.sv
// rtl/intf_burst.sv - valid/ready burst link with producer and consumer views
interface intf_burst #(
  parameter int W = 16
) ();
  logic         bvalid;
  logic         bready;
  logic [W-1:0] bdata;

  modport downstream (input bvalid, input bdata, output bready);
  modport upstream   (output bvalid, output bdata, input bready);
endinterface

// File: rtl/burst_out_reg.sv
// rtl/burst_out_reg.sv - valid/ready output holding register (load, hold, drain)
module burst_out_reg #(
  parameter int W = 64
) (
  input  logic         i_sysclk,
  input  logic         i_srst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A load in the same cycle as a drain replaces the word and keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && i_ready) valid_d = 1'b0;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/burst_deserializer.sv
// rtl/burst_deserializer.sv - packs RATIO narrow beats into one wide output word
module burst_deserializer
  import burst_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RATIO = 4
) (
  input  logic                          i_sysclk,
  input  logic                          i_srst,
  input  logic                          i_flush,
  intf_burst.downstream                 s_burst,
  intf_burst.upstream                   m_burst,
  output logic [beat_idx_w(RATIO)-1:0]  o_beat_idx
);

  `BURST_RATIO_CHECK(RATIO)

  localparam int                IDX_W = beat_idx_w(RATIO);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0]             beat_idx_q, beat_idx_d;
  logic [(RATIO-1)*WIDTH-1:0]   asm_q, asm_d;
  logic                         s_ready;
  logic                         accept;
  logic                         is_last;
  logic                         load;
  logic                         m_valid;
  logic [WIDTH*RATIO-1:0]       m_data;
  logic [WIDTH-1:0]             s_data;

  assign s_data  = s_burst.bdata;
  assign is_last = (beat_idx_q == LAST);
  // Only the final beat of a word needs the output slot to be free.
  assign s_ready = !i_srst && !i_flush && (!is_last || !m_valid || m_burst.bready);
  assign accept  = s_burst.bvalid && s_ready;
  assign load    = accept && is_last;

  always_comb begin
    beat_idx_d = beat_idx_q;
    asm_d      = asm_q;
    if (i_flush) begin
      beat_idx_d = '0;
    end else if (accept) begin
      if (is_last) begin
        beat_idx_d = '0;
      end else begin
        beat_idx_d = beat_idx_q + IDX_W'(1);
        asm_d[int'(beat_idx_q)*WIDTH +: WIDTH] = s_data;
      end
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_srst) beat_idx_q <= '0;
    else        beat_idx_q <= beat_idx_d;
    asm_q <= asm_d;
  end

  burst_out_reg #(
    .W (WIDTH*RATIO)
  ) u_out_reg (
    .i_sysclk (i_sysclk),
    .i_srst   (i_srst),
    .i_load   (load),
    .i_data   ({s_data, asm_q}),
    .i_ready  (m_burst.bready),
    .o_valid  (m_valid),
    .o_data   (m_data)
  );

  assign s_burst.bready = s_ready;
  assign m_burst.bvalid = m_valid;
  assign m_burst.bdata  = m_data;
  assign o_beat_idx     = beat_idx_q;

endmodule

// File: tb/tb_burst_deserializer.sv
// tb/tb_burst_deserializer.sv - scoreboard bench for burst_deserializer
module tb_burst_deserializer;

  localparam int WIDTH = 16;
  localparam int RATIO = 4;

  logic       clk = 1'b0;
  logic       srst;
  logic       flush;
  logic [1:0] o_beat_idx;

  intf_burst #(.W(WIDTH))       s_if ();
  intf_burst #(.W(WIDTH*RATIO)) m_if ();

  burst_deserializer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .i_sysclk   (clk),
    .i_srst     (srst),
    .i_flush    (flush),
    .s_burst    (s_if),
    .m_burst    (m_if),
    .o_beat_idx (o_beat_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  logic [WIDTH-1:0]       pb[$];
  logic [WIDTH*RATIO-1:0] exp_q[$];
  bit                     out_full  = 0;
  bit                     was_reset = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a slot for the output word and a list of held beats.
  always @(negedge clk) begin
    bit                     exp_br;
    bit                     load;
    logic [WIDTH*RATIO-1:0] w;
    #1;
    if (srst) begin
      chk("bready_in_reset", 64'(s_if.bready), 64'(0));
      pb.delete();
      exp_q.delete();
      out_full  = 0;
      was_reset = 1;
    end else begin
      if (was_reset) begin
        chk("rst_bvalid", 64'(m_if.bvalid), 64'(0));
        chk("rst_bdata", m_if.bdata, 64'(0));
        chk("rst_beat_idx", 64'(o_beat_idx), 64'(0));
        was_reset = 0;
      end
      exp_br = !flush && (pb.size() != RATIO-1 || !out_full || m_if.bready);
      chk("s_bready", 64'(s_if.bready), 64'(exp_br));
      chk("beat_idx", 64'(o_beat_idx), 64'(pb.size()));
      chk("m_bvalid", 64'(m_if.bvalid), 64'(out_full));
      load = 0;
      if (flush) begin
        pb.delete();
      end else if (s_if.bvalid && exp_br) begin
        pb.push_back(s_if.bdata);
        n_acc++;
        if (pb.size() == RATIO) begin
          w = '0;
          for (int i = 0; i < RATIO; i++) w[i*WIDTH +: WIDTH] = pb[i];
          exp_q.push_back(w);
          pb.delete();
          load = 1;
        end
      end
      out_full = load || (out_full && !m_if.bready);
    end
  end

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    #1;
    if (!srst && m_if.bvalid && m_if.bready) begin
      if (exp_q.size() == 0) chk("unexpected_word", m_if.bdata, 64'hDEAD_0000_0000_DEAD);
      else                   chk("word", m_if.bdata, exp_q.pop_front());
    end
  end

  task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit mr, input bit fl, input bit rs);
    @(negedge clk);
    s_if.bvalid = v;
    s_if.bdata  = d;
    m_if.bready = mr;
    flush       = fl;
    srst        = rs;
  endtask

  initial begin
    int cycles;
    srst = 1; flush = 0; s_if.bvalid = 0; s_if.bdata = '0; m_if.bready = 0;
    cyc(0, 16'h0, 0, 0, 1);
    cyc(0, 16'h0, 0, 0, 1);

    // basic packing
    cyc(1, 16'h1111, 1, 0, 0);
    cyc(1, 16'h2222, 1, 0, 0);
    cyc(1, 16'h3333, 1, 0, 0);
    cyc(1, 16'h4444, 1, 0, 0);
    repeat (3) cyc(0, 16'h0, 1, 0, 0);

    // full rate
    for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 1, 0, 0);
    repeat (2) cyc(0, 16'h0, 1, 0, 0);

    // output stall
    for (int i = 1; i <= 4; i++) cyc(1, 16'(i), 1, 0, 0);
    for (int i = 5; i <= 7; i++) cyc(1, 16'(i), 0, 0, 0);
    repeat (3) cyc(1, 16'h0008, 0, 0, 0);
    cyc(1, 16'h0008, 1, 0, 0);
    repeat (3) cyc(0, 16'h0, 1, 0, 0);

    // flush
    cyc(1, 16'hAAAA, 1, 0, 0);
    cyc(1, 16'hBBBB, 1, 0, 0);
    cyc(1, 16'hCCCC, 1, 1, 0);
    cyc(1, 16'h1111, 1, 0, 0);
    cyc(1, 16'h2222, 1, 0, 0);
    cyc(1, 16'h3333, 1, 0, 0);
    cyc(1, 16'h4444, 1, 0, 0);
    repeat (3) cyc(0, 16'h0, 1, 0, 0);

    // reset mid-word with a stalled output word
    for (int i = 1; i <= 6; i++) cyc(1, 16'(16'h0100 + i), 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) cyc(1, 16'(16'h0200 + i), 1, 0, 0);
    repeat (3) cyc(0, 16'h0, 1, 0, 0);

    // randomised traffic
    n_acc  = 0;
    cycles = 0;
    while (n_acc < 10000 && cycles < 60000) begin
      cyc($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
          $urandom_range(0, 99) == 0, 0);
      cycles++;
    end
    if (cycles >= 60000) chk("random_timeout", 64'(n_acc), 64'(10000));
    repeat (5) cyc(0, 16'h0, 1, 0, 0);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
